// File: rtl/z80_wb_pkg.sv
// z80_wb_pkg: definitions shared by the Z80-to-Wishbone bridge files.
//   state_t      - bridge sequencer states
//   ADR_IO_BIT   - Wishbone address bit that marks an I/O-space cycle
//   IACK_DEFAULT - default data returned on interrupt-acknowledge cycles
package z80_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RETRY,
        ST_DONE
    } state_t;

    localparam int unsigned ADR_IO_BIT   = 16;
    localparam logic [7:0]  IACK_DEFAULT = 8'hFF;

endpackage

// File: rtl/z80_bus_sync.sv
// z80_bus_sync: bank of two-flop synchronisers for the active-low CPU strobes.
// Reset and idle value is all-ones, so a reset never presents a request.
// With SYNC_IN = 0 the strobes pass straight through.
//   clk_i, rst_i  system clock, asynchronous active-high reset
//   strobes_raw   strobes straight from the CPU pins
//   strobes       synchronised strobes
module z80_bus_sync #(
    parameter int unsigned SYNC_IN = 1,
    parameter int unsigned W       = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] strobes_raw,
    output logic [W-1:0] strobes
);

    generate
        if (SYNC_IN != 0) begin : g_sync
            logic [W-1:0] meta;
            logic [W-1:0] stable;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    meta   <= '1;
                    stable <= '1;
                end else begin
                    meta   <= strobes_raw;
                    stable <= meta;
                end
            end

            assign strobes = stable;
        end else begin : g_direct
            assign strobes = strobes_raw;
        end
    endgenerate

endmodule

// File: rtl/z80_wb_bridge.sv
// z80_wb_bridge: turns Z80 memory / I/O bus cycles into single 8-bit Wishbone
// classic cycles, holding the CPU in WAIT until the slave answers.
// Retry, error, timeout, refresh and interrupt-acknowledge are handled locally.
//   clk_i, rst_i            system clock, asynchronous active-high reset
//   z_addr_i, z_data_i      CPU address / write data
//   z_data_o                read data to CPU, held until the CPU cycle ends
//   z_*_n_i                 CPU strobes (active-low)
//   z_wait_n_o              WAIT to CPU (active-low, combinational)
//   wb_*                    Wishbone classic master (adr bit16 = I/O space)
//   bus_err_o, bus_tmo_o    sticky error / timeout flags
//   err_clr_i               single-cycle clear of both sticky flags
module z80_wb_bridge
    import z80_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned SYNC_IN   = 1,
    parameter logic [7:0]  IACK_VEC  = IACK_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] z_addr_i,
    input  logic [7:0]  z_data_i,
    output logic [7:0]  z_data_o,
    input  logic        z_mreq_n_i,
    input  logic        z_iorq_n_i,
    input  logic        z_rd_n_i,
    input  logic        z_wr_n_i,
    input  logic        z_m1_n_i,
    input  logic        z_rfsh_n_i,
    output logic        z_wait_n_o,
    output logic [16:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        bus_err_o,
    output logic        bus_tmo_o,
    input  logic        err_clr_i
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [5:0] strobes;
    logic       mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;

    z80_bus_sync #(
        .SYNC_IN (SYNC_IN),
        .W       (6)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .strobes_raw ({z_mreq_n_i, z_iorq_n_i, z_rd_n_i, z_wr_n_i, z_m1_n_i, z_rfsh_n_i}),
        .strobes     (strobes)
    );

    assign {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n} = strobes;

    logic mem_req, io_req, iack, req;

    assign mem_req = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
    assign io_req  = ~iorq_n & m1_n & (~rd_n | ~wr_n);
    assign iack    = ~iorq_n & ~m1_n;
    assign req     = mem_req | io_req;

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;

    assign z_wait_n_o = ~(req && (state == ST_IDLE || state == ST_BUS || state == ST_RETRY));
    assign wb_sel_o   = wb_stb_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            z_data_o  <= '1;
            bus_err_o <= 1'b0;
            bus_tmo_o <= 1'b0;
        end else begin
            // Clear first so that a flag set later in this cycle takes priority.
            if (err_clr_i) begin
                bus_err_o <= 1'b0;
                bus_tmo_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        wb_adr_o  <= {io_req, z_addr_i};
                        wb_we_o   <= ~wr_n;
                        wb_dat_o  <= z_data_i;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        timer     <= '0;
                        retry_cnt <= '0;
                        state     <= ST_BUS;
                    end else if (iack) begin
                        z_data_o <= IACK_VEC;
                        state    <= ST_DONE;
                    end
                end

                ST_BUS: begin
                    if (wb_ack_i) begin
                        if (!wb_we_o) z_data_o <= wb_dat_i;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        timer    <= '0;
                        state    <= ST_DONE;
                    end else if (wb_err_i || (wb_rty_i && retry_cnt == RETRY_MAX)) begin
                        if (!wb_we_o) z_data_o <= '1;
                        bus_err_o <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        timer     <= '0;
                        state     <= ST_DONE;
                    end else if (wb_rty_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        retry_cnt <= retry_cnt + 1'b1;
                        timer     <= '0;
                        state     <= ST_RETRY;
                    end else if (timer == TMO_LAST) begin
                        // The TIMEOUT-th cycle with the strobe up has just ended.
                        z_data_o  <= '1;
                        bus_err_o <= 1'b1;
                        bus_tmo_o <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        timer     <= '0;
                        state     <= ST_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_RETRY: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    timer    <= '0;
                    state    <= ST_BUS;
                end

                ST_DONE: begin
                    if (!req && !iack) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_wb_bridge.sv
// tb_z80_wb_bridge: directed, table-driven bench for z80_wb_bridge plus
// hand-written sequences for refresh / iack and reset during a bus cycle.
module tb_z80_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] z_addr_i = '0;
    logic [7:0]  z_data_i = '0;
    logic [7:0]  z_data_o;
    logic        z_mreq_n_i = 1'b1, z_iorq_n_i = 1'b1, z_rd_n_i = 1'b1;
    logic        z_wr_n_i = 1'b1, z_m1_n_i = 1'b1, z_rfsh_n_i = 1'b1;
    logic        z_wait_n_o;
    logic [16:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        bus_err_o, bus_tmo_o;
    logic        err_clr_i = 1'b0;

    always #5 clk_i = ~clk_i;

    z80_wb_bridge #(
        .TIMEOUT   (8),
        .MAX_RETRY (3),
        .SYNC_IN   (1),
        .IACK_VEC  (8'hE7)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .z_addr_i   (z_addr_i),
        .z_data_i   (z_data_i),
        .z_data_o   (z_data_o),
        .z_mreq_n_i (z_mreq_n_i),
        .z_iorq_n_i (z_iorq_n_i),
        .z_rd_n_i   (z_rd_n_i),
        .z_wr_n_i   (z_wr_n_i),
        .z_m1_n_i   (z_m1_n_i),
        .z_rfsh_n_i (z_rfsh_n_i),
        .z_wait_n_o (z_wait_n_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i),
        .bus_err_o  (bus_err_o),
        .bus_tmo_o  (bus_tmo_o),
        .err_clr_i  (err_clr_i)
    );

    // ---------------- slave model ----------------
    // Answers dly+1 cycles after the strobe is seen; first hands out retries
    // until rty_total reaches s_rty_limit, then responds according to s_mode
    // (0 = ack, 1 = err, 2 = silent).
    int         s_dly = 0;
    int         s_mode = 0;
    int         s_rty_limit = 0;
    int         rty_total = 0;
    int         s_cnt = 0;
    logic [7:0] s_rdata = '0;

    assign wb_dat_i = s_rdata;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_rty_i <= 1'b0;
            s_cnt    <= 0;
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_rty_i <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !(wb_ack_i || wb_err_i || wb_rty_i)) begin
                if (s_cnt == s_dly) begin
                    s_cnt <= 0;
                    if (rty_total < s_rty_limit) begin
                        wb_rty_i  <= 1'b1;
                        rty_total <= rty_total + 1;
                    end else if (s_mode == 0) begin
                        wb_ack_i <= 1'b1;
                    end else if (s_mode == 1) begin
                        wb_err_i <= 1'b1;
                    end
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end else begin
                s_cnt <= 0;
            end
        end
    end

    // ---------------- bus monitor (cumulative counters) ----------------
    int          stb_pulses = 0, cyc_cycles = 0, wait_hi_cyc = 0, sel_bad = 0;
    logic        stb_q = 1'b0;
    logic [16:0] cap_adr = '0;
    logic [7:0]  cap_dat = '0;
    logic        cap_we = 1'b0;

    always @(posedge clk_i) begin
        #1;
        if (!rst_i) begin
            if (wb_stb_o && !stb_q) begin
                stb_pulses++;
                cap_adr = wb_adr_o;
                cap_dat = wb_dat_o;
                cap_we  = wb_we_o;
            end
            if (wb_cyc_o) begin
                cyc_cycles++;
                if (z_wait_n_o) wait_hi_cyc++;
            end
            if (wb_sel_o !== wb_stb_o) sel_bad++;
        end
        stb_q = wb_stb_o;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          dly;
        int          nrty;
        int          mode;
        logic [7:0]  rdata;
        logic [16:0] e_adr;
        logic [7:0]  e_dat;
        logic        chk_z;
        logic [7:0]  e_z;
        logic        e_err;
        logic        e_tmo;
        int          e_stb;
        int          e_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic cpu_idle();
        z_mreq_n_i = 1'b1; z_iorq_n_i = 1'b1; z_rd_n_i = 1'b1;
        z_wr_n_i = 1'b1;   z_m1_n_i = 1'b1;   z_rfsh_n_i = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  p0, c0, w0;
        bit  ok;
        @(negedge clk_i) err_clr_i = 1'b1;
        @(negedge clk_i) err_clr_i = 1'b0;
        chk($sformatf("v%0d_clr_err", idx), bus_err_o, 1'b0);
        chk($sformatf("v%0d_clr_tmo", idx), bus_tmo_o, 1'b0);

        s_dly = v.dly; s_mode = v.mode; s_rdata = v.rdata;
        s_rty_limit = rty_total + v.nrty;
        p0 = stb_pulses; c0 = cyc_cycles; w0 = wait_hi_cyc;

        z_addr_i = v.addr; z_data_i = v.wdata;
        if (v.io) z_iorq_n_i = 1'b0; else z_mreq_n_i = 1'b0;
        if (v.wr) z_wr_n_i = 1'b0; else z_rd_n_i = 1'b0;

        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (!z_wait_n_o) begin ok = 1; break; end
        end
        chk($sformatf("v%0d_wait_low", idx), ok, 1'b1);
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (wb_stb_o) begin ok = 1; break; end
            @(negedge clk_i);
        end
        chk($sformatf("v%0d_stb_seen", idx), ok, 1'b1);
        // changes on the CPU side during the bus cycle must be ignored
        z_addr_i = ~v.addr; z_data_i = ~v.wdata;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (z_wait_n_o) begin ok = 1; break; end
        end
        chk($sformatf("v%0d_wait_release", idx), ok, 1'b1);

        chk($sformatf("v%0d_adr", idx), cap_adr, v.e_adr);
        chk($sformatf("v%0d_dat", idx), cap_dat, v.e_dat);
        chk($sformatf("v%0d_we", idx), cap_we, v.wr);
        if (v.chk_z) chk($sformatf("v%0d_zdata", idx), z_data_o, v.e_z);
        chk($sformatf("v%0d_bus_err", idx), bus_err_o, v.e_err);
        chk($sformatf("v%0d_bus_tmo", idx), bus_tmo_o, v.e_tmo);
        chk($sformatf("v%0d_stb_pulses", idx), stb_pulses - p0, v.e_stb);
        chk($sformatf("v%0d_cyc_cycles", idx), cyc_cycles - c0, v.e_cyc);
        chk($sformatf("v%0d_wait_hi_in_cyc", idx), wait_hi_cyc - w0, 0);

        cpu_idle();
        repeat (5) @(negedge clk_i);
        chk($sformatf("v%0d_no_extra_cycle", idx), stb_pulses - p0, v.e_stb);
        chk($sformatf("v%0d_cyc_idle", idx), wb_cyc_o, 1'b0);
    endtask

    initial begin
        int  c0, wl;
        bit  ok;
        //            io wr addr      wd    dly nrty mode rd     e_adr      e_dat chkz e_z   err tmo stb cyc
        vecs[0] = '{1'b0, 1'b0, 16'h4000, 8'h00, 2, 0, 0, 8'hA5, 17'h04000, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 4};
        vecs[1] = '{1'b1, 1'b1, 16'h7F10, 8'h3C, 0, 0, 0, 8'h00, 17'h17F10, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1, 2};
        vecs[2] = '{1'b0, 1'b0, 16'h0123, 8'h11, 0, 0, 0, 8'h5A, 17'h00123, 8'h11, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 2};
        vecs[3] = '{1'b1, 1'b0, 16'h00FE, 8'h22, 1, 0, 0, 8'hC3, 17'h100FE, 8'h22, 1'b1, 8'hC3, 1'b0, 1'b0, 1, 3};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 0, 0, 0, 8'h99, 17'h0FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 2};
        vecs[5] = '{1'b0, 1'b0, 16'h2000, 8'h00, 0, 3, 0, 8'h77, 17'h02000, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 4, 8};
        vecs[6] = '{1'b0, 1'b0, 16'h2001, 8'h00, 0, 4, 0, 8'h77, 17'h02001, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 4, 8};
        vecs[7] = '{1'b0, 1'b0, 16'h3000, 8'h00, 1, 0, 1, 8'h77, 17'h03000, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1, 3};
        vecs[8] = '{1'b0, 1'b0, 16'h5000, 8'h00, 0, 0, 2, 8'h00, 17'h05000, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 1, 8};

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_adr", wb_adr_o, 17'h0);
        chk("rst_dat", wb_dat_o, 8'h00);
        chk("rst_zdata", z_data_o, 8'hFF);
        chk("rst_wait", z_wait_n_o, 1'b1);
        chk("rst_err", bus_err_o, 1'b0);
        chk("rst_tmo", bus_tmo_o, 1'b0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // refresh cycle: no Wishbone activity, no wait
        c0 = cyc_cycles; wl = 0;
        z_mreq_n_i = 1'b0; z_rfsh_n_i = 1'b0;
        repeat (8) begin @(negedge clk_i); if (!z_wait_n_o) wl++; end
        chk("rfsh_no_cyc", cyc_cycles - c0, 0);
        chk("rfsh_no_wait", wl, 0);
        cpu_idle();
        repeat (4) @(negedge clk_i);

        // interrupt acknowledge: vector returned, no Wishbone activity, no wait
        c0 = cyc_cycles; wl = 0;
        z_iorq_n_i = 1'b0; z_m1_n_i = 1'b0;
        repeat (8) begin @(negedge clk_i); if (!z_wait_n_o) wl++; end
        chk("iack_no_cyc", cyc_cycles - c0, 0);
        chk("iack_no_wait", wl, 0);
        chk("iack_vec", z_data_o, 8'hE7);
        cpu_idle();
        repeat (4) @(negedge clk_i);

        // asynchronous reset while a bus cycle is open
        s_mode = 2; s_dly = 0; s_rty_limit = rty_total;
        z_addr_i = 16'h1234; z_mreq_n_i = 1'b0; z_rd_n_i = 1'b0;
        ok = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (wb_stb_o) begin ok = 1; break; end
        end
        chk("rstbus_stb_seen", ok, 1'b1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("rstbus_cyc", wb_cyc_o, 1'b0);
        chk("rstbus_stb", wb_stb_o, 1'b0);
        chk("rstbus_wait", z_wait_n_o, 1'b1);
        chk("rstbus_zdata", z_data_o, 8'hFF);
        @(negedge clk_i);
        cpu_idle();
        @(negedge clk_i) rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rstbus_err", bus_err_o, 1'b0);
        run_vec(9, vecs[0]);

        chk("sel_tracks_stb", sel_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/z80_wb_bridge.md
Name: z80_wb_bridge

Overview:
- Converts Z80-style CPU bus cycles (memory and I/O read/write) into single 8-bit Wishbone classic cycles.
- Sits directly upstream of the interconnect's 8-bit CPU master port; its Wishbone outputs feed the 8-to-16 CPU width converter.
- Stretches CPU cycles with WAIT until the slave acks, errors, or the bridge times out.
- Handles retry, error, timeout, refresh and interrupt-acknowledge cycles locally.

Parameters:
- TIMEOUT, 255, clk_i cycles without ack/err/rty before the bridge aborts the cycle (1..1023).
- MAX_RETRY, 3, rty_i responses accepted per cycle; the next one is treated as an error.
- SYNC_IN, 1, 1 = two-flop synchronise CPU strobes (CPU asynchronous to clk_i); 0 = sample directly.
- IACK_VEC, 8'hFF, data returned on interrupt-acknowledge cycles.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- z_addr_i  in  16  CPU address
- z_data_i  in  8  CPU write data
- z_data_o  out  8  read data to CPU; held until the CPU cycle ends
- z_mreq_n_i / z_iorq_n_i / z_rd_n_i / z_wr_n_i / z_m1_n_i / z_rfsh_n_i  in  1 each  CPU strobes, active-low
- z_wait_n_o  out  1  WAIT to CPU, active-low
- wb_adr_o  out  17  bit16 = 1 for I/O cycles; [15:0] = z_addr_i
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_we_o / wb_cyc_o / wb_stb_o  out  1 each  Wishbone master controls
- wb_sel_o  out  1  byte select; equals wb_stb_o
- wb_ack_i / wb_err_i / wb_rty_i  in  1 each  slave responses
- bus_err_o  out  1  sticky: set on error or timeout, cleared by err_clr_i
- bus_tmo_o  out  1  sticky: set on timeout only, cleared by err_clr_i
- err_clr_i  in  1  single-cycle clear of both sticky flags

Behaviour:
Reset (asynchronous):
- All Wishbone outputs 0.
- z_data_o = 8'hFF, z_wait_n_o = 1, sticky flags 0, state IDLE.

Request decode (on the synchronised strobes, SYNC_IN latency 2 clk_i cycles):
- mem_req = ~mreq_n & rfsh_n & (~rd_n | ~wr_n). Refresh cycles never generate a request.
- io_req = ~iorq_n & m1_n & (~rd_n | ~wr_n).
- iack = ~iorq_n & ~m1_n.
- req = mem_req | io_req.

z_wait_n_o:
- Combinational: 0 when req is true and state is IDLE, BUS or RETRY; 1 otherwise.
- Low in the same cycle the synchronised request is first seen.

States:
- IDLE: on req, latch adr (bit16 = io_req), we = ~wr_n, dat_o = z_data_i. Assert cyc/stb/sel next cycle. Clear timer and retry counter. Go to BUS.
  - On iack: z_data_o = IACK_VEC, go to DONE, no Wishbone cycle.
- BUS: cyc = stb = 1; the timer increments every cycle. Resolution order when several responses arrive in the same cycle: ack > err > rty.
  - ack: latch wb_dat_i into z_data_o if read; drop cyc/stb; go to DONE.
  - err: z_data_o = 8'hFF (reads); set bus_err_o; go to DONE.
  - rty with retries < MAX_RETRY: drop stb and cyc for exactly one cycle; increment retry count; go to RETRY.
  - rty with retries = MAX_RETRY: handled as err.
  - Timer reaches TIMEOUT: drop cyc/stb; z_data_o = 8'hFF; set bus_err_o and bus_tmo_o; go to DONE.
- RETRY: one cycle with cyc = stb = 0, then reassert with the same adr/dat/we. Go to BUS; the timer restarts from 0.
- DONE: cyc = stb = 0; wait released. Stay until req and iack are both false, then go to IDLE. This guarantees exactly one Wishbone cycle per CPU cycle.

Other rules:
- Address and data are latched at cycle start only; CPU changes during BUS are ignored.
- CPU strobes deasserting mid-cycle (CPU reset) do not abort: the Wishbone cycle completes normally, then DONE exits immediately.
- err_clr_i in the same cycle as a new flag set: the set wins.
- rst_i mid-cycle drops cyc/stb immediately (asynchronous).
- Timer width is clog2(TIMEOUT+1); no wrap is possible because it is cleared on every exit from BUS.

Decomposition:
- Shared package z80_wb_pkg holds:
  - state enum typedef (IDLE, BUS, RETRY, DONE)
  - ADR_IO_BIT = 16 constant
  - IACK default constant
- Sub-module z80_bus_sync: parameterised two-flop synchroniser bank for the six strobes; pass-through when SYNC_IN = 0.

Test Plan:
- Memory read 0x4000, slave acks 3 cycles after stb with 8'hA5: wb_adr_o = 17'h04000, we = 0, wait low until the ack cycle, z_data_o = 8'hA5, exactly one stb pulse.
- I/O write 0x7F10 with data 8'h3C, ack after 1 cycle: wb_adr_o = 17'h17F10, wb_dat_o = 8'h3C, we = 1, bus_err_o stays 0.
- Refresh cycle (mreq_n = 0, rfsh_n = 0, rd_n = 1) followed by iack: no cyc asserted in either; z_data_o = 8'hFF on iack with no wait.
- Slave asserts rty three times then ack with MAX_RETRY = 3: four stb windows separated by 1-cycle gaps, read completes normally. A 4th rty instead of the ack gives bus_err_o = 1 and z_data_o = 8'hFF.
- No response with TIMEOUT = 8: cyc drops after 8 cycles, bus_tmo_o = bus_err_o = 1, wait released. err_clr_i pulse clears both flags.
- rst_i asserted during BUS: cyc/stb = 0 asynchronously, wait_n = 1. After release, the next CPU read runs normally.
